// File: rtl/gpu_pkg.sv
// Shared constants and types for the GPU drawing pipeline.
package gpu_pkg;

  localparam int WIDTH_BITS  = 10;
  localparam int HEIGHT_BITS = 9;

  typedef enum logic [2:0] {
    OCT_0, OCT_1, OCT_2, OCT_3, OCT_4, OCT_5, OCT_6, OCT_7
  } oct_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

endpackage

// File: rtl/gpu_octant_map.sv
// Maps a first-octant offset (x,y) around a centre onto screen coordinates for one octant.
module gpu_octant_map #(
  parameter int WIDTH_BITS  = gpu_pkg::WIDTH_BITS,
  parameter int HEIGHT_BITS = gpu_pkg::HEIGHT_BITS
) (
  input  logic [WIDTH_BITS-1:0]  xC,
  input  logic [HEIGHT_BITS-1:0] yC,
  input  logic [WIDTH_BITS-1:0]  x,
  input  logic [WIDTH_BITS-1:0]  y,
  input  gpu_pkg::oct_t          oct,
  output logic [WIDTH_BITS-1:0]  X,
  output logic [HEIGHT_BITS-1:0] Y
);
  import gpu_pkg::*;

  logic [HEIGHT_BITS-1:0] xh, yh;

  // Vertical sums wrap modulo 2^HEIGHT_BITS, so only the low offset bits matter.
  assign xh = x[HEIGHT_BITS-1:0];
  assign yh = y[HEIGHT_BITS-1:0];

  always_comb begin
    X = '0;
    Y = '0;
    unique case (oct)
      OCT_0: begin X = xC + x; Y = yC + yh; end
      OCT_1: begin X = xC + y; Y = yC + xh; end
      OCT_2: begin X = xC - y; Y = yC + xh; end
      OCT_3: begin X = xC - x; Y = yC + yh; end
      OCT_4: begin X = xC - x; Y = yC - yh; end
      OCT_5: begin X = xC - y; Y = yC - xh; end
      OCT_6: begin X = xC + y; Y = yC - xh; end
      OCT_7: begin X = xC + x; Y = yC - yh; end
      default: begin X = '0; Y = '0; end
    endcase
  end

endmodule

// File: rtl/gpu_octant_draw.sv
// Midpoint circle rasteriser for one octant: one registered pixel per clock while busy.
module gpu_octant_draw #(
  parameter int WIDTH_BITS  = gpu_pkg::WIDTH_BITS,
  parameter int HEIGHT_BITS = gpu_pkg::HEIGHT_BITS
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [WIDTH_BITS-1:0]  xC,
  input  logic [HEIGHT_BITS-1:0] yC,
  input  logic [WIDTH_BITS-1:0]  rad,
  input  logic [2:0]             oct,
  input  logic                   start,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [WIDTH_BITS-1:0]  X,
  output logic [HEIGHT_BITS-1:0] Y
);
  import gpu_pkg::*;

  localparam int DW = WIDTH_BITS + 3;

  state_t state, state_next;

  logic [WIDTH_BITS-1:0]  x_q, y_q, xc_q;
  logic [HEIGHT_BITS-1:0] yc_q;
  oct_t                   oct_q;
  logic signed [DW-1:0]   d_q, d_next, delta, ny_s, nx_s;
  logic signed [WIDTH_BITS:0] nx;
  logic [WIDTH_BITS-1:0]  ny;
  logic                   step_x, last;

  logic [WIDTH_BITS-1:0]  map_xc, map_x, map_y, pix_x;
  logic [HEIGHT_BITS-1:0] map_yc, pix_y;
  oct_t                   map_oct;

  // nx carries a sign bit so that x stepping below zero (rad=0) still ends the run.
  always_comb begin
    step_x = ~d_q[DW-1];
    ny     = y_q + WIDTH_BITS'(1);
    nx     = $signed({1'b0, x_q}) - $signed((WIDTH_BITS+1)'(step_x));
    ny_s   = $signed(DW'(ny));
    nx_s   = DW'(nx);
    delta  = step_x ? (ny_s - nx_s) : ny_s;
    d_next = d_q + delta + delta + DW'(1);
    last   = $signed({1'b0, ny}) > nx;
  end

  // In IDLE the map sees the live request so the first pixel is registered on the start edge.
  always_comb begin
    if (state == IDLE) begin
      map_xc  = xC;
      map_yc  = yC;
      map_x   = rad;
      map_y   = '0;
      map_oct = oct_t'(oct);
    end else begin
      map_xc  = xc_q;
      map_yc  = yc_q;
      map_x   = nx[WIDTH_BITS-1:0];
      map_y   = ny;
      map_oct = oct_q;
    end
  end

  gpu_octant_map #(
    .WIDTH_BITS (WIDTH_BITS),
    .HEIGHT_BITS(HEIGHT_BITS)
  ) u_map (
    .xC (map_xc),
    .yC (map_yc),
    .x  (map_x),
    .y  (map_y),
    .oct(map_oct),
    .X  (pix_x),
    .Y  (pix_y)
  );

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = DRAW;
      DRAW: begin
        busy_o = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      x_q   <= '0;
      y_q   <= '0;
      d_q   <= '0;
      xc_q  <= '0;
      yc_q  <= '0;
      oct_q <= OCT_0;
      X     <= '0;
      Y     <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          xc_q  <= xC;
          yc_q  <= yC;
          oct_q <= oct_t'(oct);
          x_q   <= rad;
          y_q   <= '0;
          d_q   <= DW'(1) - $signed(DW'(rad));
          X     <= pix_x;
          Y     <= pix_y;
        end
        DRAW: if (!last) begin
          x_q <= nx[WIDTH_BITS-1:0];
          y_q <= ny;
          d_q <= d_next;
          X   <= pix_x;
          Y   <= pix_y;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_octant_draw.sv
// Bench for gpu_octant_draw: pixel streams checked against a behavioural midpoint-circle model.
module tb_gpu_octant_draw;

  localparam int W = 10;
  localparam int H = 9;
  localparam int MAX_CYC = 4000;

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic [W-1:0] xC = '0;
  logic [H-1:0] yC = '0;
  logic [W-1:0] rad = '0;
  logic [2:0]   oct = '0;
  logic         start = 1'b0;
  logic         busy_o, done_o;
  logic [W-1:0] X;
  logic [H-1:0] Y;

  int tests = 0;
  int fails = 0;
  int got_x[$], got_y[$], exp_x[$], exp_y[$];

  always #5 clk = ~clk;

  gpu_octant_draw #(.WIDTH_BITS(W), .HEIGHT_BITS(H)) dut (
    .clk(clk), .n_rst(n_rst), .xC(xC), .yC(yC), .rad(rad), .oct(oct),
    .start(start), .busy_o(busy_o), .done_o(done_o), .X(X), .Y(Y)
  );

  // Reference: integer midpoint circle, then octant reflection, wrapped to screen width.
  task automatic model(input int xc, input int yc, input int r, input int o);
    int x, y, d, px, py;
    exp_x.delete();
    exp_y.delete();
    x = r; y = 0; d = 1 - r;
    while (y <= x) begin
      case (o)
        0: begin px = xc + x; py = yc + y; end
        1: begin px = xc + y; py = yc + x; end
        2: begin px = xc - y; py = yc + x; end
        3: begin px = xc - x; py = yc + y; end
        4: begin px = xc - x; py = yc - y; end
        5: begin px = xc - y; py = yc - x; end
        6: begin px = xc + y; py = yc - x; end
        default: begin px = xc + x; py = yc - y; end
      endcase
      exp_x.push_back(px & ((1 << W) - 1));
      exp_y.push_back(py & ((1 << H) - 1));
      y = y + 1;
      if (d < 0) d = d + 2 * y + 1;
      else begin
        x = x - 1;
        d = d + 2 * (y - x) + 1;
      end
    end
  endtask

  task automatic capture(input int xc, input int yc, input int r, input int o,
                         input int hold, input bit scramble);
    int cyc;
    bit bad;
    got_x.delete();
    got_y.delete();
    @(negedge clk);
    xC = W'(xc); yC = H'(yc); rad = W'(r); oct = 3'(o); start = 1'b1;
    @(negedge clk);
    tests++;
    if (busy_o !== 1'b1) begin
      fails++;
      $display("FAIL start_latency: busy_o=%b required 1", busy_o);
    end
    cyc = 0;
    bad = 1'b0;
    while (busy_o === 1'b1 && cyc < MAX_CYC) begin
      if (done_o !== 1'b0) bad = 1'b1;
      got_x.push_back(int'(X));
      got_y.push_back(int'(Y));
      if (scramble) begin
        xC = W'($urandom); yC = H'($urandom); rad = W'($urandom); oct = 3'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cyc >= MAX_CYC) begin
      fails++;
      $display("FAIL draw_timeout: busy for %0d cycles, required end within %0d", cyc, MAX_CYC);
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL busy_done_overlap: done_o=1 seen while busy_o=1, required never");
    end
    tests++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL completion: busy_o=%b done_o=%b required busy_o=0 done_o=1", busy_o, done_o);
    end
    bad = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (busy_o !== 1'b0 || done_o !== 1'b1) bad = 1'b1;
    end
    if (hold > 0) begin
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL no_redraw: state left DONE with start held, required busy_o=0 done_o=1");
      end
    end
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      fails++;
      $display("FAIL return_idle: busy_o=%b done_o=%b required 0 0", busy_o, done_o);
    end
  endtask

  task automatic compare(input string name);
    int n;
    tests++;
    if (got_x.size() != exp_x.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d pixels, required %0d", name, got_x.size(), exp_x.size());
    end
    n = (got_x.size() < exp_x.size()) ? got_x.size() : exp_x.size();
    for (int i = 0; i < n; i++) begin
      tests++;
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
        fails++;
        $display("FAIL %s_pixel[%0d]: got (%0d,%0d) required (%0d,%0d)",
                 name, i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || X !== '0 || Y !== '0) begin
      fails++;
      $display("FAIL reset_values: busy=%b done=%b X=%0d Y=%0d required 0 0 0 0", busy_o, done_o, X, Y);
    end
    @(negedge clk);
    n_rst = 1'b0;
  endtask

  task automatic test_reset_mid_draw();
    @(negedge clk);
    xC = W'(320); yC = H'(240); rad = W'(200); oct = 3'd0; start = 1'b1;
    repeat (10) @(negedge clk);
    n_rst = 1'b1;
    #1;
    tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || X !== '0 || Y !== '0) begin
      fails++;
      $display("FAIL reset_mid_draw: busy=%b done=%b X=%0d Y=%0d required 0 0 0 0", busy_o, done_o, X, Y);
    end
    start = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    capture(320, 240, 200, 0, 0, 1'b0);
    model(320, 240, 200, 0);
    compare("redraw_after_reset");
  endtask

  task automatic test_small();
    capture(320, 240, 0, 0, 3, 1'b0);
    tests++;
    if (got_x.size() != 1 || (got_x.size() == 1 && (got_x[0] != 320 || got_y[0] != 240))) begin
      fails++;
      $display("FAIL rad0: got %0d pixels first (%0d,%0d) required 1 pixel (320,240)",
               got_x.size(), got_x.size() > 0 ? got_x[0] : -1, got_y.size() > 0 ? got_y[0] : -1);
    end
    capture(320, 240, 2, 0, 0, 1'b0);
    model(320, 240, 2, 0);
    compare("rad2_oct0");
    tests++;
    if (exp_x.size() != 2 || got_x.size() != 2 || got_x[1] != 322 || got_y[1] != 241) begin
      fails++;
      $display("FAIL rad2_oct0_last: got %0d pixels required 2 ending (322,241)", got_x.size());
    end
    capture(320, 240, 2, 4, 0, 1'b0);
    model(320, 240, 2, 4);
    compare("rad2_oct4");
  endtask

  task automatic test_full_circle();
    int cnt[8];
    int dx, dy, err;
    bit bad;
    for (int o = 0; o < 8; o++) begin
      capture(320, 240, 200, o, 150, 1'b0);
      model(320, 240, 200, o);
      compare("circle");
      cnt[o] = got_x.size();
      bad = 1'b0;
      foreach (got_x[i]) begin
        dx = got_x[i] - 320;
        dy = got_y[i] - 240;
        err = dx * dx + dy * dy - 40000;
        if (err > 200 || err < -200) bad = 1'b1;
      end
      tests++;
      if (bad || got_x.size() == 0) begin
        fails++;
        $display("FAIL circle_error oct %0d: pixel off radius or no pixels (%0d)", o, got_x.size());
      end
      if (got_x.size() > 0 && (o == 0 || o == 1 || o == 4 || o == 6)) begin
        int ex, ey;
        case (o)
          0: begin ex = 520; ey = 240; end
          1: begin ex = 320; ey = 440; end
          4: begin ex = 120; ey = 240; end
          default: begin ex = 320; ey = 40; end
        endcase
        tests++;
        if (got_x[0] != ex || got_y[0] != ey) begin
          fails++;
          $display("FAIL first_pixel oct %0d: got (%0d,%0d) required (%0d,%0d)", o, got_x[0], got_y[0], ex, ey);
        end
      end
    end
    for (int o = 1; o < 8; o++) begin
      tests++;
      if (cnt[o] != cnt[0]) begin
        fails++;
        $display("FAIL octant_count oct %0d: got %0d required %0d", o, cnt[o], cnt[0]);
      end
    end
  endtask

  task automatic test_wrap();
    capture(1000, 240, 100, 0, 0, 1'b0);
    model(1000, 240, 100, 0);
    compare("wrap");
    tests++;
    if (got_x.size() == 0 || got_x[0] != 76) begin
      fails++;
      $display("FAIL wrap_first_x: got %0d required 76", got_x.size() > 0 ? got_x[0] : -1);
    end
  endtask

  task automatic test_random_scrambled();
    int xc, yc, r, o;
    for (int k = 0; k < 12; k++) begin
      xc = int'($urandom_range(1023, 0));
      yc = int'($urandom_range(511, 0));
      r  = int'($urandom_range(150, 0));
      o  = int'($urandom_range(7, 0));
      capture(xc, yc, r, o, 2, 1'b1);
      model(xc, yc, r, o);
      compare("random");
    end
  endtask

  task automatic test_back_to_back();
    capture(100, 100, 30, 2, 0, 1'b0);
    model(100, 100, 30, 2);
    compare("b2b_first");
    capture(500, 300, 45, 5, 0, 1'b0);
    model(500, 300, 45, 5);
    compare("b2b_second");
  endtask

  initial begin
    test_reset();
    test_small();
    test_reset_mid_draw();
    test_full_circle();
    test_wrap();
    test_random_scrambled();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
